// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide engine for the Execute stage: one result bit per
// cycle, owns HI/LO and stalls the pipeline while an operation is in flight.
//
// state  | meaning
// IDLE   | waiting for mult/multu/div/divu; mfhi/mflo served combinationally
// MUL    | WIDTH shift-add iterations on |a| * |b|
// DIV    | WIDTH restoring-division iterations on |a| / |b|
// FIX    | sign correction and divide-by-zero override
// DONE   | HI/LO written, done pulsed, instruction released
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             stall,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] result
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MUL  = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [2:0] F_MULT  = 3'b001;
  localparam logic [2:0] F_MULTU = 3'b010;
  localparam logic [2:0] F_DIV   = 3'b011;
  localparam logic [2:0] F_DIVU  = 3'b100;
  localparam logic [2:0] F_MFHI  = 3'b101;
  localparam logic [2:0] F_MFLO  = 3'b110;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [2:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   a_orig;
  logic               sa;
  logic               sb;
  logic               is_div;
  logic               dz;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               dbz_q;

  logic               f_mul;
  logic               f_div;
  logic               f_sgn;
  logic               accept;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_sh;
  logic               ge;
  logic [WIDTH-1:0]   rem_new;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] fix_val;

  always_comb begin
    f_mul  = (funct == F_MULT) || (funct == F_MULTU);
    f_div  = (funct == F_DIV)  || (funct == F_DIVU);
    f_sgn  = (funct == F_MULT) || (funct == F_DIV);
    accept = (state == S_IDLE) && start && !flush && (f_mul || f_div);
    a_abs  = (f_sgn && a[WIDTH-1]) ? -a : a;
    b_abs  = (f_sgn && b[WIDTH-1]) ? -b : b;
  end

  // Shift-add: the carry out of the upper-half add becomes the new MSB.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_next = {mul_sum, acc[WIDTH-1:1]};
  end

  // Restoring step; a successful trial always leaves a remainder below the
  // divisor, so only the low WIDTH bits of the difference are needed.
  always_comb begin
    rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    ge       = rem_sh >= {1'b0, opnd};
    rem_new  = ge ? (rem_sh[WIDTH-1:0] - opnd) : rem_sh[WIDTH-1:0];
    div_next = {rem_new, acc[WIDTH-2:0], ge};
  end

  always_comb begin
    fix_val = acc;
    if (dz) begin
      fix_val = {a_orig, {WIDTH{1'b1}}};
    end else if (is_div) begin
      fix_val[2*WIDTH-1:WIDTH] = sa ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      fix_val[WIDTH-1:0]       = (sa ^ sb) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    end else if (sa ^ sb) begin
      fix_val = -acc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      a_orig <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      is_div <= 1'b0;
      dz     <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      dbz_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            acc    <= {{WIDTH{1'b0}}, f_div ? a_abs : b_abs};
            opnd   <= f_div ? b_abs : a_abs;
            a_orig <= a;
            sa     <= f_sgn && a[WIDTH-1];
            sb     <= f_sgn && b[WIDTH-1];
            is_div <= f_div;
            dz     <= f_div && (b == '0);
            cnt    <= '0;
            state  <= f_div ? S_DIV : S_MUL;
          end
        end
        S_MUL, S_DIV: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            acc <= (state == S_DIV) ? div_next : mul_next;
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_LAST) state <= S_FIX;
          end
        end
        S_FIX: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            acc   <= fix_val;
            state <= S_DONE;
            if (dz) dbz_q <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          if (!flush) begin
            hi_q <= acc[2*WIDTH-1:WIDTH];
            lo_q <= acc[WIDTH-1:0];
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs are forced low during reset so the reset cycle itself is quiet.
  always_comb begin
    stall = !reset && (((state != S_IDLE) && (state != S_DONE)) ||
                       ((state == S_IDLE) && start && (f_mul || f_div)));
    done  = !reset && (state == S_DONE) && !flush;
    if (reset || !start)          result = '0;
    else if (funct == F_MFHI)     result = hi_q;
    else if (funct == F_MFLO)     result = lo_q;
    else                          result = '0;
  end

  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed operations push expected
// HI/LO, a monitor pops on each done pulse and checks the registers after it.
module tb_muldiv_sequencer;
  localparam int W = 32;

  localparam logic [2:0] F_MULT  = 3'b001;
  localparam logic [2:0] F_MULTU = 3'b010;
  localparam logic [2:0] F_DIV   = 3'b011;
  localparam logic [2:0] F_DIVU  = 3'b100;
  localparam logic [2:0] F_MFHI  = 3'b101;
  localparam logic [2:0] F_MFLO  = 3'b110;

  logic         clk   = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [2:0]   funct = 3'b000;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         stall;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic [W-1:0] result;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_done   = 0;

  muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .funct(funct), .a(a), .b(b),
    .flush(flush), .stall(stall), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Monitor: on every done pulse, pop and compare HI/LO one cycle later.
  always begin
    @(negedge clk);
    if (done) begin
      n_done++;
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no pending op");
      end else begin
        mon_e = sb_q.pop_front();
        @(negedge clk);
        check("hi", hi, mon_e.hi);
        check("lo", lo, mon_e.lo);
      end
    end
  end

  task automatic issue(input logic [2:0] f, input logic [W-1:0] av, input logic [W-1:0] bv);
    @(negedge clk);
    start = 1'b1;
    funct = f;
    a     = av;
    b     = bv;
    #1;
    check1("stall_at_accept", stall, 1'b1);
  endtask

  // Returns at the negedge of the done cycle (state DONE).
  task automatic run_op(input logic [2:0] f, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                        input int hold_cyc);
    int cyc;
    int stall_bad;
    exp_t e;
    e.hi = exp_hi;
    e.lo = exp_lo;
    sb_q.push_back(e);
    issue(f, av, bv);
    cyc = 0;
    stall_bad = 0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc >= hold_cyc) start = 1'b0;
      if (!done && !stall) stall_bad++;
    end
    check("done_cycle", W'(cyc), W'(W + 2));
    check1("stall_in_done", stall, 1'b0);
    check("stall_gaps", W'(stall_bad), '0);
  endtask

  task automatic abort_op(input logic use_reset, input logic [W-1:0] exp_hi,
                          input logic [W-1:0] exp_lo, input logic exp_dbz);
    int snap;
    snap = n_done;
    issue(F_MULT, 32'd6, 32'd7);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    if (use_reset) reset = 1'b1;
    else flush = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    flush = 1'b0;
    #1;
    check1("abort_stall", stall, 1'b0);
    check1("abort_done", done, 1'b0);
    check("abort_hi", hi, exp_hi);
    check("abort_lo", lo, exp_lo);
    check("abort_result", result, '0);
    check1("abort_dbz", div_by_zero, exp_dbz);
    repeat (40) @(negedge clk);
    check("abort_no_done", W'(n_done), W'(snap));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish expected finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int snap;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_hi", hi, '0);
    check("rst_lo", lo, '0);
    check("rst_result", result, '0);
    check1("rst_done", done, 1'b0);
    check1("rst_stall", stall, 1'b0);
    check1("rst_dbz", div_by_zero, 1'b0);

    // -3 * 5 = -15
    run_op(F_MULT, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1);

    // (2^32-1)^2
    run_op(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1);
    @(negedge clk);
    start = 1'b1;
    funct = F_MFLO;
    #1;
    check("mflo_result", result, 32'h00000001);
    check1("mflo_stall", stall, 1'b0);
    @(negedge clk);
    start = 1'b0;

    // -7 / 2 -> q=-3 r=-1 ; most-negative / -1 wraps
    run_op(F_DIV, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1);
    run_op(F_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1);

    run_op(F_DIVU, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 1);
    check1("dbz_set", div_by_zero, 1'b1);
    run_op(F_DIVU, 32'd10, 32'd3, 32'd1, 32'd3, 1);
    check1("dbz_sticky", div_by_zero, 1'b1);

    abort_op(1'b0, 32'd1, 32'd3, 1'b1);
    abort_op(1'b1, 32'd0, 32'd0, 1'b0);

    // start held for 40 cycles: one done, the restart at cycle 35 is flushed
    snap = n_done;
    run_op(F_MULT, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 40);
    repeat (6) @(negedge clk);
    start = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check1("hold_stall", stall, 1'b0);
    check("hold_hi", hi, 32'hFFFFFFFF);
    repeat (40) @(negedge clk);
    check("hold_one_done", W'(n_done), W'(snap + 1));

    // mfhi in DONE sees old HI, next cycle sees new HI
    run_op(F_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 1);
    start = 1'b1;
    funct = F_MFHI;
    #1;
    check("mfhi_in_done", result, 32'hFFFFFFFF);
    @(negedge clk);
    #1;
    check("mfhi_after_done", result, 32'h00000000);
    start = 1'b0;

    repeat (5) @(negedge clk);
    check("scoreboard_empty", W'(sb_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative multiply/divide engine with its own sequencing FSM. Replaces the single-cycle multiply/divide unit in the Execute stage.
- Accepts one MulDivFunct operation per issue and computes one bit per cycle.
- Holds the pipeline with a stall request while busy. Owns the HI/LO registers.
- stall feeds the hazard unit: it is ORed into Stall_F and Stall_D, and holds the D/E register.

Parameters:
WIDTH, 32, operand, HI and LO width (even, >= 4)
CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > WIDTH

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
start  in  1  Execute stage holds a valid MulDivFunct instruction
funct  in  3  000 nop, 001 mult, 010 multu, 011 div, 100 divu, 101 mfhi, 110 mflo, 111 reserved (nop)
a  in  WIDTH  rs value (multiplicand or dividend)
b  in  WIDTH  rt value (multiplier or divisor)
flush  in  1  abort the in-flight operation
stall  out  1  hold the pipeline
done  out  1  one-cycle pulse when HI/LO are updated
div_by_zero  out  1  sticky flag, set by div/divu with b=0
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register
result  out  WIDTH  mfhi/mflo read data, to write_out_E

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high.
- Reset values:
  - State IDLE.
  - hi=0, lo=0, result=0.
  - done=0, stall=0, div_by_zero=0.
  - Counter=0. Internal accumulator and operand copies=0.
- Reset has priority over every other input, including mid-operation. The operation is discarded.
- FSM states: IDLE, MUL, DIV, FIX, DONE.
- IDLE:
  - start & funct in {001,010}: latch operands, go to MUL.
  - start & funct in {011,100}: latch operands, go to DIV.
  - Signed ops (001, 011) latch |a| and |b|, and record sign bits sa and sb.
  - Unsigned ops latch a and b unchanged.
  - start & funct=101 or 110: result=hi or lo, combinationally, same cycle. No stall, no state change.
  - funct 000 or 111: no effect.
- MUL (unsigned shift-add):
  - Exactly WIDTH cycles.
  - Each cycle: if the multiplier LSB is 1, add the multiplicand into the upper half of a 2*WIDTH accumulator (WIDTH+1-bit add, carry kept). Then shift right 1.
- DIV (restoring):
  - Exactly WIDTH cycles.
  - Each cycle: shift {rem, quot} left 1, then trial-subtract the divisor from rem (WIDTH+1 bits).
  - Non-negative result: keep it and set quotient bit = 1. Otherwise restore.
- Counter counts 0..WIDTH-1. On the last count, go to FIX.
- FIX, one cycle:
  - Signed mult: negate the 2*WIDTH product if sa^sb.
  - Signed div: negate the quotient if sa^sb; negate the remainder if sa.
  - Div by zero, b=0 detected at latch: lo = all ones, hi = original a. div_by_zero is set, sticky until reset.
  - Signed overflow (most-negative / -1) needs no special case: lo=most-negative, hi=0.
- DONE, one cycle:
  - hi <= upper word (remainder); lo <= lower word (quotient).
  - done=1 in this cycle only. Return to IDLE.
- Latency: with the accept at cycle 0, done is high in cycle WIDTH+2 and the new hi/lo are visible from cycle WIDTH+3.
- stall:
  - stall = (state != IDLE & state != DONE) | (state == IDLE & start & funct in {001..100}).
  - stall is low in the DONE cycle, so the instruction advances exactly once.
- start while not IDLE is ignored. The pipeline is stalled, so the same instruction is presented again; this must not restart the operation.
- flush, not in reset:
  - In a non-IDLE state: go to IDLE next cycle. hi/lo unchanged, no done pulse, stall low from the next cycle.
  - In IDLE: suppresses acceptance of start.
- mfhi/mflo in the DONE cycle return the OLD hi/lo. The hazard unit must not issue them until stall=0, which is guaranteed because they follow in program order.

Test Plan:
- Signed mult: reset, then start funct=001 a=FFFFFFFD (-3) b=00000005 → stall high cycles 0..33, done at cycle 34, hi=FFFFFFFF lo=FFFFFFF1.
- Unsigned mult: funct=010 a=FFFFFFFF b=FFFFFFFF → hi=FFFFFFFE lo=00000001; then mflo → result=00000001 with stall=0.
- Signed div: funct=011 a=FFFFFFF9 (-7) b=00000002 → lo=FFFFFFFD, hi=FFFFFFFF. Then funct=011 a=80000000 b=FFFFFFFF → lo=80000000, hi=0.
- Divide by zero: funct=100 a=00000007 b=0 → lo=FFFFFFFF, hi=00000007, div_by_zero=1 and still 1 after a later valid divu 10/3 (lo=3, hi=1).
- Abort: mult 6*7, then flush at cycle 10 → state IDLE at cycle 11, stall=0, hi/lo hold prior values, no done pulse. Repeat with reset at cycle 10 → all outputs 0, div_by_zero cleared.
- Issue/read corners: start held high for 40 cycles with funct=001 → exactly one done pulse. mfhi issued in the DONE cycle → old hi value; in the next cycle → new hi value.
